// File: rtl/ds1302_time_set.sv
// ds1302_time_set: writes a full BCD time/date into a DS1302 RTC over its
// 3-wire interface. The sequence is: clear write-protect, write the seven
// timekeeping registers, then set write-protect again.
// Optional build macro: DS1302_SET_BCD_CHECK_EN. When it is defined, a
// request that carries any non-BCD nibble is rejected with an err pulse.
module ds1302_time_set #(
   parameter int SCLK_HALF = 50,   // clk cycles per SCLK half-period, >= 2
   parameter int CE_GAP    = 200   // clk cycles CE stays low between transactions
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_req,
   input  logic [7:0] year,
   input  logic [7:0] month,
   input  logic [7:0] date,
   input  logic [7:0] week,
   input  logic [7:0] hour,
   input  logic [7:0] minute,
   input  logic [7:0] second,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       ds1302_ce,
   output logic       ds1302_sclk,
   output logic       ds1302_io_out,
   output logic       ds1302_io_oe
);

   localparam int CNT_MAX = (SCLK_HALF > CE_GAP) ? SCLK_HALF : CE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CE_GAP - 1);

   typedef enum logic [2:0] {
      IDLE, CE_SETUP, SHIFT, CE_HOLD, GAP, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       bit_cnt, bit_nxt;   // 0..15 within the 16-bit frame
   logic             phase, phase_nxt;   // 0 = SCLK low half, 1 = SCLK high half
   logic [3:0]       tx_idx, idx_nxt;    // 0..8, one per register write
   logic             load;

   logic [7:0] f_year, f_month, f_date, f_week, f_hour, f_minute, f_second;
   logic [7:0] cmd_byte, data_byte;
   logic [15:0] frame;

`ifdef DS1302_SET_BCD_CHECK_EN
   logic err_r, err_nxt;
   logic fields_bad;

   function automatic logic bcd_bad(input logic [7:0] v);
      return (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
   endfunction

   // The raw inputs are checked, so an out-of-range seconds tens nibble is
   // rejected even though the CH bit would otherwise be cleared.
   assign fields_bad = bcd_bad(year) || bcd_bad(month) || bcd_bad(date) ||
                       bcd_bad(week) || bcd_bad(hour) || bcd_bad(minute) ||
                       bcd_bad(second);
`endif

   // State register and sequencing counters.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // in this block updates from the values it held before the edge.
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         phase   <= 1'b0;
         tx_idx  <= '0;
`ifdef DS1302_SET_BCD_CHECK_EN
         err_r   <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_nxt;
         phase   <= phase_nxt;
         tx_idx  <= idx_nxt;
`ifdef DS1302_SET_BCD_CHECK_EN
         err_r   <= err_nxt;
`endif
      end
   end

   // Capture the requested time on accept; seconds go out with CH=0 so the
   // oscillator runs.
   always_ff @(posedge clk) begin
      // NOTE: these are datapath registers without a reset. They are only read
      // after a load, so resetting them would add nothing.
      if (load) begin
         f_year   <= year;
         f_month  <= month;
         f_date   <= date;
         f_week   <= week;
         f_hour   <= hour;
         f_minute <= minute;
         f_second <= {1'b0, second[6:0]};
      end
   end

   // Next-state logic and per-state timing.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case
      // infers a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      phase_nxt = phase;
      idx_nxt   = tx_idx;
      load      = 1'b0;
`ifdef DS1302_SET_BCD_CHECK_EN
      err_nxt   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            cnt_nxt   = '0;
            bit_nxt   = '0;
            phase_nxt = 1'b0;
            idx_nxt   = '0;
            if (set_req) begin
`ifdef DS1302_SET_BCD_CHECK_EN
               if (fields_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = CE_SETUP;
               end
`else
               load      = 1'b1;
               state_nxt = CE_SETUP;
`endif
            end
         end
         CE_SETUP: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               phase_nxt = 1'b0;
               state_nxt = SHIFT;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (!phase) begin
                  phase_nxt = 1'b1;
               end else begin
                  phase_nxt = 1'b0;
                  if (bit_cnt == 4'd15) state_nxt = CE_HOLD;
                  else                  bit_nxt   = bit_cnt + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         CE_HOLD: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nxt = '0;
               if (tx_idx == 4'd8) begin
                  state_nxt = DONE;
               end else begin
                  idx_nxt   = tx_idx + 1'b1;
                  state_nxt = CE_SETUP;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command/data pair for the current transaction.
   always_comb begin
      cmd_byte  = 8'h8E;
      data_byte = 8'h00;
      unique case (tx_idx)
         4'd0: begin cmd_byte = 8'h8E; data_byte = 8'h00;     end
         4'd1: begin cmd_byte = 8'h80; data_byte = f_second;  end
         4'd2: begin cmd_byte = 8'h82; data_byte = f_minute;  end
         4'd3: begin cmd_byte = 8'h84; data_byte = f_hour;    end
         4'd4: begin cmd_byte = 8'h86; data_byte = f_date;    end
         4'd5: begin cmd_byte = 8'h88; data_byte = f_month;   end
         4'd6: begin cmd_byte = 8'h8A; data_byte = f_week;    end
         4'd7: begin cmd_byte = 8'h8C; data_byte = f_year;    end
         default: begin cmd_byte = 8'h8E; data_byte = 8'h80; end
      endcase
   end

   // The command byte goes out first and each byte is sent LSB first.
   assign frame = {data_byte, cmd_byte};

   // Pin outputs are decoded from registered state. The bit index only
   // advances at the end of a high phase, so IO settles while SCLK is low.
   assign ds1302_ce     = (state == CE_SETUP) || (state == SHIFT) || (state == CE_HOLD);
   assign ds1302_io_oe  = ds1302_ce;
   assign ds1302_sclk   = (state == SHIFT) && phase;
   assign ds1302_io_out = (state == SHIFT) && frame[bit_cnt];
   assign busy          = (state != IDLE) && (state != DONE);
   assign done          = (state == DONE);
`ifdef DS1302_SET_BCD_CHECK_EN
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

endmodule
